// File: rtl/spi_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : spi_tx_sequencer
// Description : Burst sequencer for the SPI word source. Accepts a burst
//               command (word count, inter-word gap) and drives start_send and
//               next_count of the data former. It counts the words accepted by
//               the ready handshake, inserts idle gaps between words, and ends
//               a burst on abort or when ready is not seen in time.
//               All outputs are registered. An abort or timeout seen in SEND
//               raises its pulse in the first IDLE cycle. done, or an aborted
//               pulse that comes from ADVANCE/GAP, is raised in the FINISH cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_tx_sequencer #(
  parameter int P_LEN_W   = 8,
  parameter int P_GAP_W   = 4,
  parameter int P_TIMEOUT = 1000
) (
  input  logic               clk_100,
  input  logic               a_rst,
  input  logic               s_rst,
  input  logic               cmd_start,
  input  logic [P_LEN_W-1:0] cmd_len,
  input  logic [P_GAP_W-1:0] cmd_gap,
  input  logic               cmd_abort,
  input  logic               ready,
  output logic               start_send,
  output logic               next_count,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic               timeout_err,
  output logic [P_LEN_W-1:0] words_sent
);

  localparam int c_TO_W = (P_TIMEOUT > 1) ? $clog2(P_TIMEOUT + 1) : 1;
  localparam logic [c_TO_W-1:0] c_TO_MAX = c_TO_W'(P_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEND    = 3'd1,
    S_ADVANCE = 3'd2,
    S_GAP     = 3'd3,
    S_FINISH  = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [P_LEN_W-1:0] r_len;
  logic [P_LEN_W-1:0] r_words;
  logic [P_GAP_W-1:0] r_gap;
  logic [P_GAP_W-1:0] r_gap_cnt;
  logic [c_TO_W-1:0]  r_to_cnt;
  logic               r_abort_pend;

  logic               r_start_send;
  logic               r_next_count;
  logic               r_busy;
  logic               r_done;
  logic               r_aborted;
  logic               r_timeout;

  logic               w_handshake;
  logic               w_abort_req;
  logic               w_to_hit;
  logic               w_send_abort;
  logic               w_send_timeout;
  logic               w_fin_abort;
  logic               w_fin_done;

  // A word is accepted only while the request is actually presented.
  assign w_handshake = (r_state == S_SEND) && r_start_send && ready;
  // An abort seen now or remembered from an earlier cycle of this burst.
  assign w_abort_req = cmd_abort || r_abort_pend;

  generate
    if (P_TIMEOUT == 0) begin : g_no_timeout
      assign w_to_hit = 1'b0;
    end else begin : g_timeout
      // The current SEND cycle is the P_TIMEOUT-th one without acceptance.
      assign w_to_hit = (r_to_cnt == c_TO_W'(P_TIMEOUT - 1));
    end
  endgenerate

  // State register.
  always_ff @(posedge clk_100 or posedge a_rst) begin
    if (a_rst) begin
      r_state <= S_IDLE;
    end else if (s_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and the events that end a burst.
  always_comb begin
    w_state_nxt    = r_state;
    w_send_abort   = 1'b0;
    w_send_timeout = 1'b0;
    w_fin_abort    = 1'b0;
    w_fin_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_start && (cmd_len != '0)) begin
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (w_handshake) begin
          w_state_nxt = S_ADVANCE;
        end else if (w_abort_req) begin
          w_state_nxt  = S_IDLE;
          w_send_abort = 1'b1;
        end else if (w_to_hit) begin
          w_state_nxt    = S_IDLE;
          w_send_timeout = 1'b1;
        end
      end
      S_ADVANCE: begin
        if (w_abort_req) begin
          w_state_nxt = S_FINISH;
          w_fin_abort = 1'b1;
        end else if (r_words == r_len) begin
          w_state_nxt = S_FINISH;
          w_fin_done  = 1'b1;
        end else if (r_gap == '0) begin
          w_state_nxt = S_SEND;
        end else begin
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (w_abort_req) begin
          w_state_nxt = S_FINISH;
          w_fin_abort = 1'b1;
        end else if (r_gap_cnt == '0) begin
          w_state_nxt = S_SEND;
        end
      end
      S_FINISH: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Burst bookkeeping and registered outputs, all derived from the next state.
  always_ff @(posedge clk_100 or posedge a_rst) begin
    if (a_rst) begin
      r_len        <= '0;
      r_words      <= '0;
      r_gap        <= '0;
      r_gap_cnt    <= '0;
      r_to_cnt     <= '0;
      r_abort_pend <= 1'b0;
      r_start_send <= 1'b0;
      r_next_count <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_timeout    <= 1'b0;
    end else if (s_rst) begin
      r_len        <= '0;
      r_words      <= '0;
      r_gap        <= '0;
      r_gap_cnt    <= '0;
      r_to_cnt     <= '0;
      r_abort_pend <= 1'b0;
      r_start_send <= 1'b0;
      r_next_count <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_start_send <= (w_state_nxt == S_SEND);
      r_next_count <= (w_state_nxt == S_ADVANCE);
      r_busy       <= (w_state_nxt != S_IDLE);
      r_done       <= w_fin_done;
      r_aborted    <= w_fin_abort || w_send_abort;
      r_timeout    <= w_send_timeout;

      // Command is latched only when it actually starts a burst.
      if ((r_state == S_IDLE) && (w_state_nxt == S_SEND)) begin
        r_len   <= cmd_len;
        r_gap   <= cmd_gap;
        r_words <= '0;
      end else if (w_handshake) begin
        r_words <= r_words + P_LEN_W'(1);
      end

      // Timeout counts consecutive unanswered SEND cycles, restarting per word.
      if ((w_state_nxt == S_SEND) && (r_state != S_SEND)) begin
        r_to_cnt <= '0;
      end else if ((r_state == S_SEND) && !w_handshake && (r_to_cnt != c_TO_MAX)) begin
        r_to_cnt <= r_to_cnt + c_TO_W'(1);
      end

      // Gap counter is loaded in ADVANCE; GAP leaves once it reaches zero.
      if (r_state == S_ADVANCE) begin
        r_gap_cnt <= r_gap - P_GAP_W'(1);
      end else if ((r_state == S_GAP) && (r_gap_cnt != '0)) begin
        r_gap_cnt <= r_gap_cnt - P_GAP_W'(1);
      end

      // Abort is remembered while busy until the burst ends.
      if ((w_state_nxt == S_IDLE) || (w_state_nxt == S_FINISH)) begin
        r_abort_pend <= 1'b0;
      end else if ((r_state != S_IDLE) && cmd_abort) begin
        r_abort_pend <= 1'b1;
      end
    end
  end

  assign start_send  = r_start_send;
  assign next_count  = r_next_count;
  assign busy        = r_busy;
  assign done        = r_done;
  assign aborted     = r_aborted;
  assign timeout_err = r_timeout;
  assign words_sent  = r_words;

endmodule
`default_nettype wire
